seq_divider_2nbyn: RTL

- Sequential restoring divider: 2N-bit dividend by N-bit divisor, giving an N-bit quotient and an N-bit remainder.
- Produces one quotient bit per clock.
- Inverse companion to the team's shift-add sequential multiplier. It uses the same START/READY handshake, so it sits beside that block in the arithmetic datapath, and a multiplier product can be fed straight back in as a dividend.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 25 ++
 rtl/seq_divider_2nbyn.sv | 93 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential restoring divider
package div_pkg;

  localparam int N_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(N_DEF);

  localparam logic [N_DEF-1:0] Q_SAT = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift in a dividend bit, trial-subtract the divisor
module div_step
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N:0]   rem,
  input  logic         bit_in,
  input  logic [N-1:0] dvr,
  output logic [N:0]   rem_nxt,
  output logic         q_bit
);

  logic [N:0]   shifted;
  logic [N+1:0] trial;

  // The extra top bit of trial is the borrow; clear means shifted >= divisor.
  always_comb begin
    shifted = {rem[N-1:0], bit_in};
    trial   = {1'b0, shifted} - {2'b00, dvr};
    q_bit   = ~trial[N+1];
    rem_nxt = q_bit ? trial[N:0] : shifted;
  end

endmodule

// File: rtl/seq_divider_2nbyn.sv
// rtl/seq_divider_2nbyn.sv - 2N-by-N sequential restoring divider with START/READY handshake
module seq_divider_2nbyn
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           CK,
  input  logic           RST,
  input  logic           START,
  input  logic [2*N-1:0] DD,
  input  logic [N-1:0]   DV,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           READY,
  output logic           DIVZ,
  output logic           OVF
);

  localparam int CW = cnt_width(N);

  state_t          state;
  logic [N:0]      rem;
  logic [N-1:0]    qs;
  logic [N-1:0]    dvr;
  logic [CW-1:0]   cnt;
  logic [N:0]      rem_nxt;
  logic            q_bit;
  logic [N-1:0]    qs_nxt;

  div_step #(.N(N)) u_step (
    .rem     (rem),
    .bit_in  (qs[N-1]),
    .dvr     (dvr),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  assign qs_nxt = {qs[N-2:0], q_bit};

  // qs holds the unconsumed dividend bits at the top and accumulated quotient bits at the bottom.
  always_ff @(posedge CK) begin
    if (RST) begin
      state <= IDLE;
      READY <= 1'b1;
      Q     <= '0;
      R     <= '0;
      DIVZ  <= 1'b0;
      OVF   <= 1'b0;
      cnt   <= '0;
      rem   <= '0;
      qs    <= '0;
      dvr   <= '0;
    end else if (START) begin
      DIVZ  <= 1'b0;
      OVF   <= 1'b0;
      READY <= 1'b0;
      if (DV == '0) begin
        DIVZ  <= 1'b1;
        Q     <= '1;
        R     <= DD[N-1:0];
        state <= IDLE;
      end else if (DD[2*N-1:N] >= DV) begin
        OVF   <= 1'b1;
        Q     <= '1;
        R     <= DD[N-1:0];
        state <= IDLE;
      end else begin
        rem   <= {1'b0, DD[2*N-1:N]};
        qs    <= DD[N-1:0];
        dvr   <= DV;
        cnt   <= CW'(N);
        state <= BUSY;
      end
    end else begin
      case (state)
        IDLE: READY <= 1'b1;
        BUSY: begin
          rem <= rem_nxt;
          qs  <= qs_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            READY <= 1'b1;
            Q     <= qs_nxt;
            R     <= rem_nxt[N-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
